sum_accum: RTL and testbench
============================

Name: sum_accum

Overview:
- Downstream stage for the N-bit ripple adder. Consumes its (N+1)-bit sum output as a valid/ready stream.
- Accumulates CNT consecutive sums into an ACC_W-bit register and presents the block total on a valid/ready output.
- Flags arithmetic overflow per block. Used for running totals and block sums behind the adder array.

Parameters:
- N, 4, adder operand width; input sum is N+1 bits.
- CNT, 8, number of sums per block; legal range >= 1.
- ACC_W, 8, accumulator width; legal range >= N+1. The default N+1+clog2(CNT) cannot overflow.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous abort of the current block.
- in_valid  in  1  in_sum is valid.
- in_ready  out  1  block can accept in_sum.
- in_sum  in  N+1  adder result, unsigned.
- out_valid  out  1  block total available.
- out_ready  in  1  consumer takes the total.
- out_acc  out  ACC_W  block total, modulo 2^ACC_W.
- out_ovf  out  1  sticky: a carry out of ACC_W occurred during this block.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising clk edge.
- Reset state: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_ovf=0. in_ready is 1 in the first cycle after reset.
- Priority, highest first: rst, clear, normal operation.
- clear has the same effect as rst but is a functional input. A pending out_valid is dropped.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid & in_ready.
  - On accept: acc <= acc + zero-extended in_sum, truncated to ACC_W bits. ovf <= ovf | carry-out of the ACC_W-bit add.
  - cnt increments on each accepted beat; cycles with in_valid=0 leave acc/cnt unchanged.
  - When the accepted beat is number CNT (cnt==CNT-1): next state HOLD, cnt <= 0.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_acc = acc and out_ovf = ovf, both stable while out_valid=1 and out_ready=0.
  - On out_ready=1: next state ACCUM, acc <= 0, ovf <= 0, out_valid drops the next cycle.
  - No input is accepted in the handoff cycle; the next block starts the following cycle.
- Latency: out_valid asserts the cycle after the CNT-th accept. Peak throughput is CNT sums per CNT+1 cycles.
- in_ready depends only on state, never combinationally on out_ready or in_valid.
- out_acc and out_ovf hold their last value while out_valid=0 and are don't-care to the consumer; reset/clear drive them to 0.
- CNT=1: every accepted beat goes straight to HOLD; out_acc = in_sum zero-extended.
- Overflow: acc wraps modulo 2^ACC_W. ovf is cleared only by handoff, clear, or rst, never by a later add.
- Reset or clear mid-block discards the partial sum and count. No partial result is ever emitted.
- Behaviour is undefined for ACC_W < N+1 or CNT < 1; elaboration must fail for these, e.g. via a generate-time error.

Test Plan:
- Defaults (N=4, CNT=8, ACC_W=8); 8 back-to-back beats in_sum=5, out_ready=1 -> out_valid=1 one cycle after 8th accept, out_acc=40, out_ovf=0; in_ready=0 that cycle, 1 the next.
- Defaults; 8 beats in_sum=31 with in_valid gaps every other cycle -> out_acc=248, out_ovf=0; acc unchanged during gaps.
- ACC_W=7; 8 beats in_sum=31 -> out_acc=120 (248 mod 128), out_ovf=1; next block of 8x1 -> out_acc=8, out_ovf=0.
- Backpressure: block of 8x3 completes, out_ready=0 for 5 cycles with in_valid=1, in_sum=7 -> in_ready=0, out_acc=24 stable, no beats accepted. Then out_ready=1 for one cycle -> next block of 8x7 -> out_acc=56.
- rst after 3 beats of 10, then 8 beats of 2 -> all outputs 0 during reset, first out_acc=16. Repeat with clear instead of rst -> same result. Also: clear asserted while out_valid=1 -> out_valid=0 next cycle, no handoff.
- CNT=1; in_sum=17 every cycle, out_ready=1 -> out_valid pulses every 2nd cycle, out_acc=17, in_ready alternates 1/0.

Source files
------------

// File: rtl/sum_accum.sv
// sum_accum: block accumulator behind the ripple-adder array.
// Sums CNT consecutive (N+1)-bit adder results into an ACC_W-bit register
// and hands the block total (plus a sticky carry-out flag) downstream.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clear      synchronous abort of the current block (same effect as rst)
//   in_valid   in_sum is valid
//   in_ready   block can accept in_sum (depends on state only)
//   in_sum     unsigned adder result, N+1 bits
//   out_valid  block total available
//   out_ready  consumer takes the total
//   out_acc    block total modulo 2^ACC_W
//   out_ovf    a carry out of ACC_W occurred during this block
module sum_accum #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT   = 8,
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT - 1);

  // Reject parameter sets the accumulator cannot represent.
  generate
    if ((ACC_W < N + 1) || (CNT < 1)) begin : g_param_check
      $error("sum_accum: requires ACC_W >= N+1 and CNT >= 1");
    end
  endgenerate

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_acc;
  logic             r_out_ovf;

  logic [ACC_W:0]   w_sum;
  logic             w_accept;
  logic             w_last;

  // One extra bit captures the carry out of the ACC_W-bit add.
  assign w_sum    = {1'b0, r_acc} + (ACC_W + 1)'(in_sum);
  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_cnt == CNT_LAST);

  // Block FSM: ACCUM collects CNT beats, HOLD presents the total until taken.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_sum[ACC_W];
            if (w_last) begin
              // Final beat: publish the total directly from the adder result.
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_acc   <= w_sum[ACC_W-1:0];
              r_out_ovf   <= r_ovf | w_sum[ACC_W];
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // Handoff cycle accepts nothing; the next block starts one cycle later.
          if (out_ready) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_sum_accum.sv
// Testbench for sum_accum: three instances (defaults, ACC_W=7, CNT=1) share
// clock and reset; a block-level reference model tracks each instance.
module tb_sum_accum;

  localparam int unsigned N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr  [3];
  logic       iv   [3];
  logic [N:0] isum [3];
  logic       ordy [3];
  logic       ir   [3];
  logic       ov   [3];
  logic       of   [3];
  logic [7:0] acc0;
  logic [6:0] acc1;
  logic [7:0] acc2;

  sum_accum #(.N(N), .CNT(8), .ACC_W(8)) u_def (
    .clk(clk), .rst(rst), .clear(clr[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_sum(isum[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_acc(acc0),
    .out_ovf(of[0]));

  sum_accum #(.N(N), .CNT(8), .ACC_W(7)) u_w7 (
    .clk(clk), .rst(rst), .clear(clr[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_sum(isum[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_acc(acc1),
    .out_ovf(of[1]));

  sum_accum #(.N(N), .CNT(1), .ACC_W(8)) u_c1 (
    .clk(clk), .rst(rst), .clear(clr[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_sum(isum[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_acc(acc2),
    .out_ovf(of[2]));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: true (unbounded) block total, reduced modulo 2^W at block end.
  int cntp [3] = '{8, 8, 1};
  int wp   [3] = '{8, 7, 8};
  bit m_hold [3];
  int m_cnt  [3];
  int m_sum  [3];
  int m_acc  [3];
  bit m_ovf  [3];

  function automatic int dut_acc(input int k);
    case (k)
      0:       return int'(acc0);
      1:       return int'(acc1);
      default: return int'(acc2);
    endcase
  endfunction

  task automatic model_reset(input int k);
    m_hold[k] = 1'b0;
    m_cnt[k]  = 0;
    m_sum[k]  = 0;
    m_acc[k]  = 0;
    m_ovf[k]  = 1'b0;
  endtask

  // Advance model with the currently driven inputs, then clock the DUTs.
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      if (rst || clr[k]) begin
        model_reset(k);
      end else if (!m_hold[k]) begin
        if (iv[k]) begin
          m_sum[k] += int'(isum[k]);
          m_cnt[k]++;
          if (m_cnt[k] == cntp[k]) begin
            m_hold[k] = 1'b1;
            m_acc[k]  = m_sum[k] % (1 << wp[k]);
            m_ovf[k]  = (m_sum[k] >= (1 << wp[k]));
            m_cnt[k]  = 0;
            m_sum[k]  = 0;
          end
        end
      end else if (ordy[k]) begin
        m_hold[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      clr[k]  = 1'b0;
      iv[k]   = 1'b0;
      isum[k] = '0;
      ordy[k] = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (ov[k] !== 1'b0 || dut_acc(k) != 0 || of[k] !== 1'b0)
        $display("FAIL reset_outputs inst=%0d got v=%0b acc=%0d ovf=%0b want 0/0/0",
                 k, ov[k], dut_acc(k), of[k]);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (ir[k] !== 1'b1)
        $display("FAIL reset_in_ready inst=%0d got=%0b want=1", k, ir[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    iv[0] = 1'b1; isum[0] = 5'd5; ordy[0] = 1'b1;
    repeat (8) tick();
    n_chk++;
    if (ov[0] !== 1'b1 || acc0 !== 8'd40 || of[0] !== 1'b0 || ir[0] !== 1'b0)
      $display("FAIL b2b_total got v=%0b acc=%0d ovf=%0b rdy=%0b want 1/40/0/0",
               ov[0], acc0, of[0], ir[0]);
    else n_pass++;
    tick();
    n_chk++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
      $display("FAIL b2b_handoff got v=%0b rdy=%0b want 0/1", ov[0], ir[0]);
    else n_pass++;
    iv[0] = 1'b0;
  endtask

  task automatic test_gaps();
    isum[0] = 5'd31; ordy[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      iv[0] = ((i % 2) == 0);
      tick();
      if (i < 14) begin
        n_chk++;
        if (ov[0] !== 1'b0)
          $display("FAIL gaps_early_valid cycle=%0d got=%0b want=0", i, ov[0]);
        else n_pass++;
      end
    end
    n_chk++;
    if (ov[0] !== 1'b1 || acc0 !== 8'd248 || of[0] !== 1'b0)
      $display("FAIL gaps_total got v=%0b acc=%0d ovf=%0b want 1/248/0",
               ov[0], acc0, of[0]);
    else n_pass++;
    iv[0] = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    iv[1] = 1'b1; isum[1] = 5'd31; ordy[1] = 1'b1;
    repeat (8) tick();
    n_chk++;
    if (ov[1] !== 1'b1 || acc1 !== 7'd120 || of[1] !== 1'b1)
      $display("FAIL ovf_wrap got v=%0b acc=%0d ovf=%0b want 1/120/1",
               ov[1], acc1, of[1]);
    else n_pass++;
    isum[1] = 5'd1;
    tick();
    repeat (8) tick();
    n_chk++;
    if (ov[1] !== 1'b1 || acc1 !== 7'd8 || of[1] !== 1'b0)
      $display("FAIL ovf_cleared got v=%0b acc=%0d ovf=%0b want 1/8/0",
               ov[1], acc1, of[1]);
    else n_pass++;
    iv[1] = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    iv[0] = 1'b1; isum[0] = 5'd3; ordy[0] = 1'b1;
    repeat (8) tick();
    ordy[0] = 1'b0; isum[0] = 5'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || acc0 !== 8'd24)
        $display("FAIL bp_stall cycle=%0d got rdy=%0b v=%0b acc=%0d want 0/1/24",
                 i, ir[0], ov[0], acc0);
      else n_pass++;
    end
    ordy[0] = 1'b1;
    tick();
    n_chk++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
      $display("FAIL bp_release got v=%0b rdy=%0b want 0/1", ov[0], ir[0]);
    else n_pass++;
    repeat (8) tick();
    n_chk++;
    if (ov[0] !== 1'b1 || acc0 !== 8'd56 || of[0] !== 1'b0)
      $display("FAIL bp_next_block got v=%0b acc=%0d ovf=%0b want 1/56/0",
               ov[0], acc0, of[0]);
    else n_pass++;
    iv[0] = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    for (int pass = 0; pass < 2; pass++) begin
      iv[0] = 1'b1; isum[0] = 5'd10; ordy[0] = 1'b1;
      repeat (3) tick();
      if (pass == 0) rst = 1'b1; else clr[0] = 1'b1;
      tick();
      n_chk++;
      if (ov[0] !== 1'b0 || acc0 !== 8'd0 || of[0] !== 1'b0 || ir[0] !== 1'b1)
        $display("FAIL abort_outputs pass=%0d got v=%0b acc=%0d ovf=%0b rdy=%0b want 0/0/0/1",
                 pass, ov[0], acc0, of[0], ir[0]);
      else n_pass++;
      rst = 1'b0; clr[0] = 1'b0; isum[0] = 5'd2;
      repeat (8) tick();
      n_chk++;
      if (ov[0] !== 1'b1 || acc0 !== 8'd16 || of[0] !== 1'b0)
        $display("FAIL abort_restart pass=%0d got v=%0b acc=%0d ovf=%0b want 1/16/0",
                 pass, ov[0], acc0, of[0]);
      else n_pass++;
      if (pass == 0) begin
        iv[0] = 1'b0;
        tick();
      end
    end
    // Still in HOLD with a pending total: clear must drop it without a handoff.
    iv[0] = 1'b0; ordy[0] = 1'b0; clr[0] = 1'b1;
    tick();
    n_chk++;
    if (ov[0] !== 1'b0 || acc0 !== 8'd0 || ir[0] !== 1'b1)
      $display("FAIL clear_hold got v=%0b acc=%0d rdy=%0b want 0/0/1", ov[0], acc0, ir[0]);
    else n_pass++;
    clr[0] = 1'b0; ordy[0] = 1'b1;
  endtask

  task automatic test_cnt1();
    iv[2] = 1'b1; isum[2] = 5'd17; ordy[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if ((i % 2) == 0) begin
        if (ov[2] !== 1'b1 || ir[2] !== 1'b0 || acc2 !== 8'd17 || of[2] !== 1'b0)
          $display("FAIL cnt1_pulse cycle=%0d got v=%0b rdy=%0b acc=%0d want 1/0/17",
                   i, ov[2], ir[2], acc2);
        else n_pass++;
      end else begin
        if (ov[2] !== 1'b0 || ir[2] !== 1'b1)
          $display("FAIL cnt1_gap cycle=%0d got v=%0b rdy=%0b want 0/1", i, ov[2], ir[2]);
        else n_pass++;
      end
    end
    iv[2] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        isum[k] = (N + 1)'($urandom_range(0, 31));
        ordy[k] = ($urandom_range(0, 2) != 0);
        clr[k]  = ($urandom_range(0, 59) == 0);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (ir[k] !== !m_hold[k] || ov[k] !== m_hold[k] ||
            dut_acc(k) != m_acc[k] || of[k] !== m_ovf[k])
          $display("FAIL random inst=%0d cycle=%0d got rdy=%0b v=%0b acc=%0d ovf=%0b want %0b/%0b/%0d/%0b",
                   k, c, ir[k], ov[k], dut_acc(k), of[k],
                   !m_hold[k], m_hold[k], m_acc[k], m_ovf[k]);
        else n_pass++;
      end
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) model_reset(k);
    idle_all();
    test_reset();
    test_back_to_back();
    test_gaps();
    test_overflow();
    test_backpressure();
    test_abort();
    test_cnt1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
